uart_transmitter: RTL

Serializes bytes onto an asynchronous UART line (8N1, LSB first) for the off-chip host. It is the outbound counterpart to the input-conditioning path: the input path brings asynchronous pins into the `clk` domain, and this block drives a registered, glitch-free pin out of it. Bytes are accepted over a ready/valid handshake from the on-chip producer (CPU MMIO or test logic).

---
 rtl/uart_transmitter_if.sv | 19 +
 rtl/uart_transmitter.sv | 100 ++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// Byte handshake between an on-chip producer and the UART transmitter.
// The producer drives data_in/data_in_valid; the transmitter answers with data_in_ready.
interface uart_transmitter_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART serializer, LSB first, fed by a ready/valid byte handshake.
// serial_out and data_in_ready both come straight from flops so the pin never glitches.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave in_if,
    output logic              serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             ready_q, ready_d;
    logic             handshake;
    logic             bit_end;

    assign handshake          = in_if.data_in_valid & ready_q;
    assign bit_end            = (cnt_q == CNT_LAST);
    assign in_if.data_in_ready = ready_q;
    assign serial_out         = serial_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
        end
    end

    // The line flop follows the state by one cycle, so ready is held low through
    // the final stop-bit cycle on the pin: it only reopens from an IDLE state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = 1'b1;
        ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = ~handshake;
                if (handshake) begin
                    shift_d   = in_if.data_in;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                serial_d = 1'b0;
                cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                serial_d = shift_q[0];
                cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                serial_d = 1'b1;
                cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
